mem_wb_skid_reg: RTL and testbench

Parametrised Memory-Access to Write-Back pipeline register with a valid/ready handshake, a two-entry skid buffer, flush and x0-write suppression. It sits between the data-memory stage and the register-file write port, and replaces the fixed 32-bit free-running MEM/WB latch. It lets the write-back side stall, for example on a register-file port conflict, without a combinational ready path back into memory.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/mem_wb_skid_reg_if.sv | 42 ++++
 rtl/pipe_slot.sv | 26 ++
 rtl/mem_wb_skid_reg.sv | 93 +++++++++
 tb/tb_mem_wb_skid_reg.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: default widths, MEM/WB payload layout and slot-state encoding.
package pipe_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int RS_W = 2;

    // Encoded as {skid_v, main_v}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } slot_state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus4;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic [RS_W-1:0] result_src;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// MEM->WB handshake bundle: the MEM-side entry with its valid/ready and the WB-side held entry.
interface mem_wb_skid_reg_if #(
    parameter int XLEN = pipe_pkg::XLEN,
    parameter int RA_W = pipe_pkg::RA_W,
    parameter int RS_W = pipe_pkg::RS_W
) ();

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_result_m;
    logic [XLEN-1:0] read_data_m;
    logic [RA_W-1:0] rd_m;
    logic [XLEN-1:0] pc_plus4_m;
    logic            reg_write_m;
    logic [RS_W-1:0] result_src_m;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result_w;
    logic [XLEN-1:0] read_data_w;
    logic [XLEN-1:0] pc_plus4_w;
    logic [RA_W-1:0] rd_w;
    logic            reg_write_w;
    logic [RS_W-1:0] result_src_w;

    // The pipeline register itself.
    modport slave (
        input  in_valid, alu_result_m, read_data_m, rd_m, pc_plus4_m, reg_write_m, result_src_m,
        input  out_ready,
        output in_ready, out_valid, alu_result_w, read_data_w, pc_plus4_w, rd_w, reg_write_w,
        output result_src_w
    );

    // The surrounding pipeline (MEM producer plus WB consumer).
    modport master (
        output in_valid, alu_result_m, read_data_m, rd_m, pc_plus4_m, reg_write_m, result_src_m,
        output out_ready,
        input  in_ready, out_valid, alu_result_w, read_data_w, pc_plus4_w, rd_w, reg_write_w,
        input  result_src_w
    );

endinterface

// File: rtl/pipe_slot.sv
// One storage slot: payload register plus valid bit with load and clear (clear wins).
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      valid <= 1'b0;
        else if (clear) valid <= 1'b0;
        else if (load)  valid <= 1'b1;
    end

    // Payload only moves on load; a consumed entry keeps its bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with two-entry skid buffer, flush and x0-write suppression.
// Define MEM_WB_STALL_CNT_EN to add the stall_cnt WB back-pressure counter port.
module mem_wb_skid_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = pipe_pkg::XLEN,
    parameter int RA_W = pipe_pkg::RA_W,
    parameter int RS_W = pipe_pkg::RS_W
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    mem_wb_skid_reg_if.slave bus
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int PW = 3 * XLEN + RA_W + 1 + RS_W;

    logic [PW-1:0] in_pl, main_d, main_q, skid_q;
    logic          main_v, skid_v;
    logic          main_load, main_clr, skid_load, skid_clr, main_from_skid;
    logic          accept, consume, rw_q;
    slot_state_t   state;

    // x0 is hardwired, so its write enable is dropped at capture.
    assign in_pl = {bus.alu_result_m, bus.read_data_m, bus.pc_plus4_m, bus.rd_m,
                    bus.reg_write_m && (bus.rd_m != '0), bus.result_src_m};

    assign state   = slot_state_t'({skid_v, main_v});
    assign accept  = bus.in_valid && !skid_v;
    assign consume = main_v && bus.out_ready;
    assign main_d  = main_from_skid ? skid_q : in_pl;

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_ONE: begin
                    if (accept && consume) main_load = 1'b1;
                    else if (accept)       skid_load = 1'b1;
                    else if (consume)      main_clr  = 1'b1;
                end
                ST_TWO: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk(clk), .reset(reset), .load(main_load), .clear(main_clr),
        .d(main_d), .q(main_q), .valid(main_v)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clr),
        .d(in_pl), .q(skid_q), .valid(skid_v)
    );

    // in_ready comes straight from the skid valid flop, never from out_ready.
    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = main_v;
    assign {bus.alu_result_w, bus.read_data_w, bus.pc_plus4_w, bus.rd_w, rw_q,
            bus.result_src_w} = main_q;
    assign bus.reg_write_w = rw_q && main_v;

`ifdef MEM_WB_STALL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        stall_cnt <= '0;
        else if (main_v && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: streaming, back-pressure, x0, flush, async reset, stall count.
module tb_mem_wb_skid_reg;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg_if bus ();

`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    mem_wb_skid_reg dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        bus.in_valid     = v;
        bus.alu_result_m = alu;
        bus.read_data_m  = ~alu;
        bus.pc_plus4_m   = alu + 32'd4;
        bus.rd_m         = rd;
        bus.reg_write_m  = rw;
        bus.result_src_m = alu[1:0];
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        send(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_alu", bus.alu_result_w, 32'h0);
        check("rst_reg_write", 32'(bus.reg_write_w), 32'd0);
`ifdef MEM_WB_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        reset = 1'b0;

        // Streaming: one entry per cycle, one-cycle lag, in_ready stays high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'h10 + 32'(i), 5'(i + 1), 1'b1);
            step();
            check("stream_alu", bus.alu_result_w, 32'h10 + 32'(i));
            check("stream_rd", 32'(bus.rd_w), 32'(i + 1));
            check("stream_in_ready", 32'(bus.in_ready), 32'd1);
        end
        check("stream_read_data", bus.read_data_w, 32'hFFFF_FFE8);
        check("stream_pc_plus4", bus.pc_plus4_w, 32'h1B);
        send(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("stream_drained", 32'(bus.out_valid), 32'd0);

        // Back-pressure: A then B fill both slots
        bus.out_ready = 1'b0;
        send(1'b1, 32'hAAAA_0000, 5'd3, 1'b1);
        step();
        check("bp_a_valid", 32'(bus.out_valid), 32'd1);
        check("bp_a_in_ready", 32'(bus.in_ready), 32'd1);
        send(1'b1, 32'hBBBB_0000, 5'd4, 1'b1);
        step();
        check("bp_b_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold_a", bus.alu_result_w, 32'hAAAA_0000);
        send(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("bp_still_a", bus.alu_result_w, 32'hAAAA_0000);
        bus.out_ready = 1'b1;
        step();
        check("bp_then_b", bus.alu_result_w, 32'hBBBB_0000);
        check("bp_b_rd", 32'(bus.rd_w), 32'd4);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // x0 write suppression
        send(1'b1, 32'h55, 5'd0, 1'b1);
        step();
        check("x0_valid", 32'(bus.out_valid), 32'd1);
        check("x0_suppressed", 32'(bus.reg_write_w), 32'd0);
        send(1'b1, 32'h66, 5'd5, 1'b1);
        step();
        check("x5_write", 32'(bus.reg_write_w), 32'd1);
        send(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("stale_no_write", 32'(bus.reg_write_w), 32'd0);

        // Flush while both slots are full, with a colliding in_valid
        bus.out_ready = 1'b0;
        send(1'b1, 32'h1111, 5'd6, 1'b1);
        step();
        send(1'b1, 32'h2222, 5'd7, 1'b1);
        step();
        check("fl_full", 32'(bus.in_ready), 32'd0);
        send(1'b1, 32'hDEAD, 5'd8, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send(1'b0, 32'h0, 5'd0, 1'b0);
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        check("fl_in_ready", 32'(bus.in_ready), 32'd1);
        check("fl_no_dead", bus.alu_result_w, 32'h1111);
        bus.out_ready = 1'b1;
        step();
        check("fl_stays_empty", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset between edges with both slots full
        bus.out_ready = 1'b0;
        send(1'b1, 32'hE0, 5'd9, 1'b1);
        step();
        send(1'b1, 32'hF0, 5'd10, 1'b1);
        step();
        send(1'b0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check("ar_in_ready", 32'(bus.in_ready), 32'd1);
        check("ar_alu", bus.alu_result_w, 32'h0);
        check("ar_rd", 32'(bus.rd_w), 32'd0);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(1'b1, 32'h77, 5'd11, 1'b1);
        step();
        check("ar_first", bus.alu_result_w, 32'h77);
        check("ar_first_valid", 32'(bus.out_valid), 32'd1);
        send(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("ar_alone", 32'(bus.out_valid), 32'd0);

`ifdef MEM_WB_STALL_CNT_EN
        // Five stalled cycles with an entry held
        bus.out_ready = 1'b0;
        send(1'b1, 32'h88, 5'd12, 1'b1);
        step();
        send(1'b0, 32'h0, 5'd0, 1'b0);
        repeat (5) step();
        check("stall_cnt", stall_cnt, 32'd5);
        bus.out_ready = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
